// File: rtl/led_sequencer.sv
// led_sequencer: prescaled LED pattern generator with OFF/BLINK/CHASE/FILL modes
module led_sequencer #(
    parameter int CLK_HZ  = 12000000,
    parameter int TICK_HZ = 10,
    parameter int N_LED   = 4
) (
    input  logic             iCLK,
    input  logic             iRST,
    input  logic             iMODE_REQ,
    input  logic             iPAUSE,
    output logic [N_LED-1:0] oLED,
    output logic [1:0]       oMODE,
    output logic             oTICK
);
    localparam int DIV = CLK_HZ / TICK_HZ;
    localparam int CW  = (DIV < 2) ? 1 : $clog2(DIV);
    localparam int SW  = $clog2(N_LED + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(DIV - 1);

    if (DIV < 2) begin : g_bad_div
        $error("led_sequencer: CLK_HZ/TICK_HZ must be at least 2");
    end
    if (N_LED < 2 || N_LED > 16) begin : g_bad_nled
        $error("led_sequencer: N_LED must be in 2..16");
    end

    typedef enum logic [1:0] {OFF, BLINK, CHASE, FILL} mode_t;

    mode_t         mode_q, mode_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [SW-1:0] step_q, step_d, step_nxt;
    logic          req_q, req_d;
    logic          mode_edge;

    assign mode_edge = iMODE_REQ && !req_q;
    assign oTICK     = (cnt_q == CNT_LAST) && !iPAUSE;

    always_comb begin
        step_nxt = (mode_q == BLINK) ? ((step_q == '0) ? SW'(1) : '0) :
                   (mode_q == CHASE) ? ((step_q == SW'(N_LED - 1)) ? '0 : step_q + SW'(1)) :
                   (mode_q == FILL)  ? ((step_q == SW'(N_LED)) ? '0 : step_q + SW'(1)) :
                   '0;
    end

    // a mode request outranks both pause and a coincident tick
    always_comb begin
        req_d  = iMODE_REQ;
        mode_d = mode_q;
        cnt_d  = cnt_q;
        step_d = step_q;
        if (mode_edge) begin
            mode_d = mode_t'(mode_q + 2'd1);
            cnt_d  = '0;
            step_d = '0;
        end else if (!iPAUSE) begin
            cnt_d  = (cnt_q == CNT_LAST) ? '0 : cnt_q + CW'(1);
            step_d = (cnt_q == CNT_LAST) ? step_nxt : step_q;
        end
    end

    always_ff @(posedge iCLK) begin
        if (iRST) begin
            mode_q <= OFF;
            cnt_q  <= '0;
            step_q <= '0;
            req_q  <= iMODE_REQ;
        end else begin
            mode_q <= mode_d;
            cnt_q  <= cnt_d;
            step_q <= step_d;
            req_q  <= req_d;
        end
    end

    always_comb begin
        oMODE = mode_q;
        oLED  = (mode_q == BLINK) ? {N_LED{step_q[0]}} :
                (mode_q == CHASE) ? (N_LED'(1) << step_q) :
                (mode_q == FILL)  ? ~({N_LED{1'b1}} << step_q) :
                '0;
    end
endmodule

// File: tb/tb_led_sequencer.sv
// tb_led_sequencer: directed self-checking bench for led_sequencer at DIV=10, N_LED=4
module tb_led_sequencer;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       req = 1'b0;
    logic       pause = 1'b0;
    logic [3:0] led;
    logic [1:0] mode;
    logic       tick;
    int         n_cmp = 0;
    int         n_err = 0;

    led_sequencer #(.CLK_HZ(100), .TICK_HZ(10), .N_LED(4)) dut (
        .iCLK(clk), .iRST(rst), .iMODE_REQ(req), .iPAUSE(pause),
        .oLED(led), .oMODE(mode), .oTICK(tick)
    );

    always #5 clk = ~clk;

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic mode_req();
        req = 1'b1;
        cyc(1);
        req = 1'b0;
    endtask

    initial begin
        req = 1'b1;
        cyc(2);
        chk("rst_mode", 32'(mode), 0);
        chk("rst_led", 32'(led), 0);
        chk("rst_tick", 32'(tick), 0);
        rst = 1'b0;
        for (int i = 0; i < 50; i++) begin
            chk("idle_mode", 32'(mode), 0);
            chk("idle_led", 32'(led), 0);
            chk("idle_tick", 32'(tick), (i % 10 == 9) ? 1 : 0);
            cyc(1);
        end
        req = 1'b0;
        cyc(1);
        chk("held_req_mode", 32'(mode), 0);
        mode_req();
        chk("blink_mode", 32'(mode), 1);
        chk("blink_led0", 32'(led), 0);
        chk("blink_tick0", 32'(tick), 0);
        cyc(4);
        pause = 1'b1;
        for (int i = 0; i < 35; i++) begin
            cyc(1);
            chk("pause_led", 32'(led), 0);
            chk("pause_tick", 32'(tick), 0);
        end
        pause = 1'b0;
        for (int i = 1; i <= 6; i++) begin
            chk("resume_tick", 32'(tick), (i == 6) ? 1 : 0);
            cyc(1);
            chk("resume_led", 32'(led), (i == 6) ? 32'hf : 0);
        end
        cyc(9);
        chk("last_tick", 32'(tick), 1);
        pause = 1'b1;
        #1;
        chk("pause_at_last_tick", 32'(tick), 0);
        cyc(3);
        chk("pause_at_last_led", 32'(led), 32'hf);
        chk("pause_at_last_tick2", 32'(tick), 0);
        pause = 1'b0;
        #1;
        chk("unpause_tick", 32'(tick), 1);
        cyc(1);
        chk("unpause_led", 32'(led), 0);
        pause = 1'b1;
        mode_req();
        chk("paused_req_mode", 32'(mode), 2);
        chk("paused_req_led", 32'(led), 32'h1);
        cyc(20);
        chk("paused_chase_led", 32'(led), 32'h1);
        chk("paused_chase_tick", 32'(tick), 0);
        pause = 1'b0;
        for (int i = 0; i < 50; i++) begin
            chk("chase_led", 32'(led), 32'(1) << ((i / 10) % 4));
            chk("chase_tick", 32'(tick), (i % 10 == 9) ? 1 : 0);
            cyc(1);
        end
        chk("chase_wrap_led", 32'(led), 32'h2);
        mode_req();
        chk("fill_mode", 32'(mode), 3);
        for (int i = 0; i < 60; i++) begin
            chk("fill_led", 32'(led), (32'(1) << ((i / 10) % 5)) - 1);
            cyc(1);
        end
        mode_req();
        chk("wrap_off_mode", 32'(mode), 0);
        chk("wrap_off_led", 32'(led), 0);
        cyc(1);
        mode_req();
        chk("blink2_mode", 32'(mode), 1);
        cyc(1);
        mode_req();
        chk("chase2_mode", 32'(mode), 2);
        cyc(9);
        chk("coincide_tick", 32'(tick), 1);
        chk("coincide_led_before", 32'(led), 32'h1);
        req = 1'b1;
        cyc(1);
        req = 1'b0;
        chk("coincide_mode", 32'(mode), 3);
        chk("coincide_led", 32'(led), 0);
        for (int i = 0; i < 10; i++) begin
            chk("coincide_first_tick", 32'(tick), (i == 9) ? 1 : 0);
            cyc(1);
        end
        chk("fill_step1_led", 32'(led), 32'h1);
        cyc(15);
        chk("mid_fill_led", 32'(led), 32'h3);
        rst = 1'b1;
        cyc(1);
        chk("mid_rst_mode", 32'(mode), 0);
        chk("mid_rst_led", 32'(led), 0);
        chk("mid_rst_tick", 32'(tick), 0);
        rst = 1'b0;
        cyc(2);
        chk("post_rst_mode", 32'(mode), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/led_sequencer.md
Name: led_sequencer

Overview:
- Pattern controller that drives the board LED bank from the 12 MHz system clock.
- Prescales the clock to a step tick and runs a mode FSM (OFF, BLINK, CHASE, FILL).
- A mode-request input cycles through the modes; a pause input freezes the animation.
- Sits between the board clock and the LED pins and replaces the per-LED free-running blinkers.

Parameters:
- CLK_HZ, 12000000, input clock frequency in Hz.
- TICK_HZ, 10, step rate in Hz.
  - DIV = CLK_HZ/TICK_HZ, truncated.
  - DIV >= 2 is required; otherwise elaboration fails.
- N_LED, 4, number of LED outputs, 2..16.

Ports:
- iCLK  in  1  system clock, rising edge.
- iRST  in  1  reset; synchronous, active-high.
- iMODE_REQ  in  1  a rising edge requests the next mode; level otherwise ignored.
- iPAUSE  in  1  level; high freezes the prescaler and pattern.
- oLED  out  N_LED  LED drive, 1 = on.
- oMODE  out  2  current mode: 0 OFF, 1 BLINK, 2 CHASE, 3 FILL.
- oTICK  out  1  one-cycle step strobe.

Behaviour:
- Reset: iRST is sampled only at the iCLK rising edge. While iRST is high at an edge:
  - mode = OFF; prescaler = 0; step = 0;
  - oLED = 0; oTICK = 0;
  - the edge-detect register loads the current iMODE_REQ, so a request held high through reset does not trigger a change.
  - Reset overrides all other inputs, including mid-pattern.
- Prescaler:
  - cnt counts 0..DIV-1 and wraps to 0; width = clog2(DIV).
  - oTICK = (cnt == DIV-1) && !iPAUSE, combinational from registered cnt.
  - When iPAUSE is high, cnt holds its value.
- Step advance: at the edge ending a cycle with oTICK = 1, step advances per mode:
  - OFF: step stays 0.
  - BLINK: step toggles between 0 and 1.
  - CHASE: step counts 0..N_LED-1, then wraps to 0.
  - FILL: step counts 0..N_LED, then wraps to 0.
- oLED decode: pure function of the registered mode and step; no combinational path from inputs.
  - OFF: all zeros.
  - BLINK: all ones if step = 1, else all zeros.
  - CHASE: one-hot, bit[step] set.
  - FILL: low `step` bits set ((1<<step)-1); step = N_LED gives all ones.
- Mode request:
  - edge = iMODE_REQ && !prev, where prev is registered every cycle.
  - At the edge that samples edge = 1:
    - mode advances OFF->BLINK->CHASE->FILL->OFF;
    - step = 0 and cnt = 0.
  - The new oMODE and its step-0 pattern are visible in the cycle after that edge (1-cycle latency).
- Simultaneous events:
  - A mode edge coinciding with oTICK = 1: the mode change wins; step and cnt reset to 0; no step advance.
  - A mode edge while iPAUSE is high is accepted: mode changes, step = 0, cnt = 0, then the block stays frozen until iPAUSE falls.
  - iPAUSE rising in a cycle where cnt = DIV-1: no tick that cycle; the tick fires in the first unpaused cycle.
- Timing and sizing:
  - One step period = DIV cycles exactly; no drift across wraps.
  - At defaults, DIV = 1,200,000 and cnt is 21 bits.

Test Plan (CLK_HZ=100, TICK_HZ=10 => DIV=10, N_LED=4):
- Reset, then idle for 50 cycles -> oMODE=0, oLED=0000. oTICK pulses every 10 cycles, 1 cycle wide, first pulse at cycle 9 after reset release.
- Hold iMODE_REQ high during reset, release reset with iMODE_REQ still high -> oMODE stays 0. A low-then-high pulse afterwards gives oMODE=1 one cycle after the edge.
- Enter CHASE, run 50 cycles -> oLED steps 0001, 0010, 0100, 1000, 0001, changing every 10 cycles (wrap verified).
- Enter FILL, run 60 cycles -> 0000, 0001, 0011, 0111, 1111, 0000.
- In BLINK, hold iPAUSE high for 35 cycles -> oLED and oTICK are frozen (oTICK = 0). After release the next toggle occurs exactly (10 - cnt_at_pause) cycles later.
- In CHASE, time the iMODE_REQ edge to coincide with oTICK=1 -> next cycle oMODE=3, oLED=0000, and the first tick follows 10 cycles later. Assert iRST mid-FILL -> all outputs 0 the next cycle.
